// File: rtl/ccu_req_arbiter.sv
// Round-robin lock arbiter in front of the single-transaction CCU FSM.
// Optional per-port grant counters are built when CCU_ARB_GNT_CNT_EN is defined.
package ccu_arb_pkg;
  typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [7:0] len; } ax_chan_t;
  typedef struct packed { logic [31:0] data; logic last; } w_chan_t;
  typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_chan_t;
  typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_chan_t;

  typedef struct packed {
    ax_chan_t aw; logic aw_valid;
    w_chan_t  w;  logic w_valid;
    logic     b_ready;
    ax_chan_t ar; logic ar_valid;
    logic     r_ready;
  } ace_req_t;

  typedef struct packed {
    logic    aw_ready; logic ar_ready; logic w_ready;
    b_chan_t b;        logic b_valid;
    r_chan_t r;        logic r_valid;
  } ace_resp_t;
endpackage

module ccu_req_arbiter #(
  parameter int unsigned NoSlvPorts = 4,
  parameter type mst_req_t  = ccu_arb_pkg::ace_req_t,
  parameter type mst_resp_t = ccu_arb_pkg::ace_resp_t,
  parameter int unsigned IdxW = (NoSlvPorts > 1) ? $clog2(NoSlvPorts) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  mst_req_t  [NoSlvPorts-1:0]    slv_req_i,
  output mst_resp_t [NoSlvPorts-1:0]    slv_resp_o,
  output mst_req_t                      mst_req_o,
  input  mst_resp_t                     mst_resp_i,
  output logic [IdxW-1:0]               gnt_idx_o,
  output logic                          busy_o,
  output logic [NoSlvPorts-1:0][31:0]   gnt_cnt_o
);

  typedef enum logic [2:0] { S_IDLE, S_AR, S_R, S_AW, S_W, S_B } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] gnt_q, gnt_d, rr_q, rr_d;
  logic [NoSlvPorts-1:0] req;
  logic [IdxW-1:0] win;
  logic            win_v;
  logic [31:0]     idx;

  always_comb begin
    for (int unsigned i = 0; i < NoSlvPorts; i++)
      req[i] = slv_req_i[i].ar_valid | slv_req_i[i].aw_valid;
  end

  // First requester at or after rr_q, wrapping modulo NoSlvPorts.
  always_comb begin
    win   = rr_q;
    win_v = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NoSlvPorts; k++) begin
      idx = (32'(rr_q) + k) % NoSlvPorts;
      if (!win_v && req[idx[IdxW-1:0]]) begin
        win_v = 1'b1;
        win   = idx[IdxW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    mst_req_o  = '0;
    slv_resp_o = '0;
    unique case (state_q)
      S_IDLE: if (win_v) begin
        gnt_d   = win;
        rr_d    = (win == IdxW'(NoSlvPorts-1)) ? '0 : win + IdxW'(1);
        state_d = slv_req_i[win].ar_valid ? S_AR : S_AW;
      end
      S_AR: begin
        mst_req_o.ar               = slv_req_i[gnt_q].ar;
        mst_req_o.ar_valid         = slv_req_i[gnt_q].ar_valid;
        slv_resp_o[gnt_q].ar_ready = mst_resp_i.ar_ready;
        if (slv_req_i[gnt_q].ar_valid && mst_resp_i.ar_ready) state_d = S_R;
      end
      S_R: begin
        slv_resp_o[gnt_q].r       = mst_resp_i.r;
        slv_resp_o[gnt_q].r_valid = mst_resp_i.r_valid;
        mst_req_o.r_ready         = slv_req_i[gnt_q].r_ready;
        if (mst_resp_i.r_valid && slv_req_i[gnt_q].r_ready && mst_resp_i.r.last)
          state_d = S_IDLE;
      end
      S_AW: begin
        mst_req_o.aw               = slv_req_i[gnt_q].aw;
        mst_req_o.aw_valid         = slv_req_i[gnt_q].aw_valid;
        slv_resp_o[gnt_q].aw_ready = mst_resp_i.aw_ready;
        if (slv_req_i[gnt_q].aw_valid && mst_resp_i.aw_ready) state_d = S_W;
      end
      S_W: begin
        mst_req_o.w               = slv_req_i[gnt_q].w;
        mst_req_o.w_valid         = slv_req_i[gnt_q].w_valid;
        slv_resp_o[gnt_q].w_ready = mst_resp_i.w_ready;
        if (slv_req_i[gnt_q].w_valid && mst_resp_i.w_ready && slv_req_i[gnt_q].w.last)
          state_d = S_B;
      end
      S_B: begin
        slv_resp_o[gnt_q].b       = mst_resp_i.b;
        slv_resp_o[gnt_q].b_valid = mst_resp_i.b_valid;
        mst_req_o.b_ready         = slv_req_i[gnt_q].b_ready;
        if (mst_resp_i.b_valid && slv_req_i[gnt_q].b_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
    end
  end

  assign gnt_idx_o = gnt_q;
  assign busy_o    = (state_q != S_IDLE);

`ifdef CCU_ARB_GNT_CNT_EN
  logic [NoSlvPorts-1:0][31:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else if (state_q == S_IDLE && win_v && cnt_q[win] != 32'hFFFF_FFFF)
      cnt_q[win] <= cnt_q[win] + 32'd1;
  end

  assign gnt_cnt_o = cnt_q;
`else
  assign gnt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ccu_req_arbiter.sv
// Directed bench for ccu_req_arbiter: cycle table plus multi-cycle lock/reset/counter sequences.
module tb_ccu_req_arbiter;
  import ccu_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ace_req_t  [3:0]       slv_req;
  ace_resp_t [3:0]       slv_resp;
  ace_req_t              mst_req;
  ace_resp_t             mst_resp;
  logic [1:0]            gnt_idx;
  logic                  busy;
  logic [3:0][31:0]      gnt_cnt;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef CCU_ARB_GNT_CNT_EN
  localparam logic [31:0] EXP_CNT0 = 32'd5;
`else
  localparam logic [31:0] EXP_CNT0 = 32'd0;
`endif

  always #5 clk = ~clk;

  ccu_req_arbiter #(.NoSlvPorts(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .slv_req_i(slv_req), .slv_resp_o(slv_resp),
    .mst_req_o(mst_req), .mst_resp_i(mst_resp),
    .gnt_idx_o(gnt_idx), .busy_o(busy), .gnt_cnt_o(gnt_cnt)
  );

  typedef struct packed {
    logic [3:0] arv, awv, wv;
    logic ar_rdy, aw_rdy, w_rdy, w_last, r_v, r_last, b_v;
  } stim_t;

  typedef struct packed {
    logic busy; logic [1:0] gnt;
    logic m_arv, m_awv, m_wv, m_rr, m_br;
    logic [31:0] m_addr;
    logic [3:0] s_ardy, s_awdy, s_wdy, s_rv, s_bv;
  } obs_t;

  typedef struct packed { stim_t s; obs_t e; } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];
  logic [1:0] order [4];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic drive(input stim_t s);
    for (int i = 0; i < 4; i++) begin
      slv_req[i]          = '0;
      slv_req[i].ar.id    = 4'(i);
      slv_req[i].ar.addr  = 32'h100 + 32'(i) * 32'd16;
      slv_req[i].ar.len   = 8'd3;
      slv_req[i].ar_valid = s.arv[i];
      slv_req[i].aw.id    = 4'(i);
      slv_req[i].aw.addr  = 32'h200 + 32'(i) * 32'd16;
      slv_req[i].aw.len   = 8'd3;
      slv_req[i].aw_valid = s.awv[i];
      slv_req[i].w.data   = 32'hD0 + 32'(i);
      slv_req[i].w.last   = s.w_last;
      slv_req[i].w_valid  = s.wv[i];
      slv_req[i].r_ready  = 1'b1;
      slv_req[i].b_ready  = 1'b1;
    end
    mst_resp          = '0;
    mst_resp.ar_ready = s.ar_rdy;
    mst_resp.aw_ready = s.aw_rdy;
    mst_resp.w_ready  = s.w_rdy;
    mst_resp.r_valid  = s.r_v;
    mst_resp.r.last   = s.r_last;
    mst_resp.r.data   = 32'hBEEF;
    mst_resp.b_valid  = s.b_v;
  endtask

  function automatic obs_t observe();
    obs_t o;
    o        = '0;
    o.busy   = busy;
    o.gnt    = gnt_idx;
    o.m_arv  = mst_req.ar_valid;
    o.m_awv  = mst_req.aw_valid;
    o.m_wv   = mst_req.w_valid;
    o.m_rr   = mst_req.r_ready;
    o.m_br   = mst_req.b_ready;
    o.m_addr = mst_req.ar_valid ? mst_req.ar.addr : (mst_req.aw_valid ? mst_req.aw.addr : 32'h0);
    for (int i = 0; i < 4; i++) begin
      o.s_ardy[i] = slv_resp[i].ar_ready;
      o.s_awdy[i] = slv_resp[i].aw_ready;
      o.s_wdy[i]  = slv_resp[i].w_ready;
      o.s_rv[i]   = slv_resp[i].r_valid;
      o.s_bv[i]   = slv_resp[i].b_valid;
    end
    return o;
  endfunction

  // Wait (bounded) for a negedge where the CCU sees ar_valid (sel=0) or w_valid (sel=1).
  task automatic wait_mst(input bit sel, output bit seen, output bit p2_touched);
    seen = 1'b0;
    p2_touched = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (slv_resp[2] != '0) p2_touched = 1'b1;
      if (sel ? mst_req.w_valid : mst_req.ar_valid) seen = 1'b1;
    end
  endtask

  initial begin
    bit seen, p2t, p2_bad;
    obs_t z;
    z = '0;
    // stim: arv awv wv ar_rdy aw_rdy w_rdy w_last r_v r_last b_v
    // exp : busy gnt m_arv m_awv m_wv m_rr m_br m_addr s_ardy s_awdy s_wdy s_rv s_bv
    tbl[0]  = '{'{4'b0000,4'b0000,4'b0000,0,0,0,0,0,0,0}, z};
    tbl[1]  = '{'{4'b0100,4'b0000,4'b0000,0,0,0,0,0,0,0}, z};
    tbl[2]  = '{'{4'b0100,4'b0000,4'b0000,1,0,0,0,0,0,0}, '{1,2'd2,1,0,0,0,0,32'h120,4'b0100,4'b0,4'b0,4'b0,4'b0}};
    tbl[3]  = '{'{4'b0000,4'b0000,4'b0000,0,0,0,0,1,0,0}, '{1,2'd2,0,0,0,1,0,32'h0,4'b0,4'b0,4'b0,4'b0100,4'b0}};
    tbl[4]  = '{'{4'b0000,4'b0000,4'b0000,0,0,0,0,0,0,0}, '{1,2'd2,0,0,0,1,0,32'h0,4'b0,4'b0,4'b0,4'b0000,4'b0}};
    tbl[5]  = tbl[3];
    tbl[6]  = tbl[3];
    tbl[7]  = '{'{4'b0000,4'b0000,4'b0000,0,0,0,0,1,1,0}, '{1,2'd2,0,0,0,1,0,32'h0,4'b0,4'b0,4'b0,4'b0100,4'b0}};
    tbl[8]  = '{'{4'b0000,4'b0000,4'b0000,0,0,0,0,0,0,0}, '{0,2'd2,0,0,0,0,0,32'h0,4'b0,4'b0,4'b0,4'b0,4'b0}};
    tbl[9]  = '{'{4'b1001,4'b0000,4'b0000,0,0,0,0,0,0,0}, '{0,2'd2,0,0,0,0,0,32'h0,4'b0,4'b0,4'b0,4'b0,4'b0}};
    tbl[10] = '{'{4'b1001,4'b0000,4'b0000,1,0,0,0,0,0,0}, '{1,2'd3,1,0,0,0,0,32'h130,4'b1000,4'b0,4'b0,4'b0,4'b0}};
    tbl[11] = '{'{4'b0001,4'b0000,4'b0000,0,0,0,0,1,1,0}, '{1,2'd3,0,0,0,1,0,32'h0,4'b0,4'b0,4'b0,4'b1000,4'b0}};
    tbl[12] = '{'{4'b0001,4'b0000,4'b0000,0,0,0,0,0,0,0}, '{0,2'd3,0,0,0,0,0,32'h0,4'b0,4'b0,4'b0,4'b0,4'b0}};
    tbl[13] = '{'{4'b0001,4'b0000,4'b0000,0,0,0,0,0,0,0}, '{1,2'd0,1,0,0,0,0,32'h100,4'b0000,4'b0,4'b0,4'b0,4'b0}};
    tbl[14] = '{'{4'b0001,4'b0000,4'b0000,1,0,0,0,0,0,0}, '{1,2'd0,1,0,0,0,0,32'h100,4'b0001,4'b0,4'b0,4'b0,4'b0}};
    tbl[15] = '{'{4'b0000,4'b0000,4'b0000,0,0,0,0,1,1,0}, '{1,2'd0,0,0,0,1,0,32'h0,4'b0,4'b0,4'b0,4'b0001,4'b0}};
    tbl[16] = '{'{4'b0010,4'b0010,4'b0000,0,0,0,0,0,0,0}, '{0,2'd0,0,0,0,0,0,32'h0,4'b0,4'b0,4'b0,4'b0,4'b0}};
    tbl[17] = '{'{4'b0010,4'b0010,4'b0000,1,1,0,0,0,0,0}, '{1,2'd1,1,0,0,0,0,32'h110,4'b0010,4'b0,4'b0,4'b0,4'b0}};
    tbl[18] = '{'{4'b0000,4'b0010,4'b0000,0,1,0,0,1,1,0}, '{1,2'd1,0,0,0,1,0,32'h0,4'b0,4'b0,4'b0,4'b0010,4'b0}};
    tbl[19] = '{'{4'b0000,4'b0010,4'b0000,0,0,0,0,0,0,0}, '{0,2'd1,0,0,0,0,0,32'h0,4'b0,4'b0,4'b0,4'b0,4'b0}};
    tbl[20] = '{'{4'b0000,4'b0010,4'b0000,0,1,0,0,0,0,0}, '{1,2'd1,0,1,0,0,0,32'h210,4'b0,4'b0010,4'b0,4'b0,4'b0}};
    tbl[21] = '{'{4'b0000,4'b0000,4'b1111,0,0,0,0,0,0,0}, '{1,2'd1,0,0,1,0,0,32'h0,4'b0,4'b0,4'b0000,4'b0,4'b0}};
    tbl[22] = '{'{4'b0000,4'b0000,4'b1111,0,0,1,0,0,0,0}, '{1,2'd1,0,0,1,0,0,32'h0,4'b0,4'b0,4'b0010,4'b0,4'b0}};
    tbl[23] = '{'{4'b0000,4'b0000,4'b1111,0,0,1,1,0,0,0}, '{1,2'd1,0,0,1,0,0,32'h0,4'b0,4'b0,4'b0010,4'b0,4'b0}};
    tbl[24] = '{'{4'b0000,4'b0000,4'b0000,0,0,0,0,0,0,1}, '{1,2'd1,0,0,0,0,1,32'h0,4'b0,4'b0,4'b0,4'b0,4'b0010}};
    tbl[25] = tbl[8];
    tbl[25].e.gnt = 2'd1;
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd3; order[3] = 2'd0;

    // Reset release, idle for 10 cycles.
    drive('0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_gnt", 64'(gnt_idx), 64'd0);
    check("idle_mst_req_zero", 64'(mst_req == '0), 64'd1);
    check("idle_slv_resp_zero", 64'(slv_resp == '0), 64'd1);
    check("idle_cnt_zero", 64'(gnt_cnt == '0), 64'd1);
    @(posedge clk); #1;

    for (int k = 0; k < NV; k++) begin
      drive(tbl[k].s);
      @(negedge clk);
      check($sformatf("vec%0d", k), 64'(observe()), 64'(tbl[k].e));
      @(posedge clk); #1;
    end

    // Ports 0,1,3 hold AR from reset: grants 0,1,3,0; port 2 stays untouched.
    rst = 1'b1;
    drive('{4'b1011,4'b0000,4'b0000,1,0,0,0,1,1,0});
    @(posedge clk); #1 rst = 1'b0;
    p2_bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_mst(1'b0, seen, p2t);
      if (p2t) p2_bad = 1'b1;
      check($sformatf("rr_seen%0d", k), 64'(seen), 64'd1);
      check($sformatf("rr_gnt%0d", k), 64'(gnt_idx), 64'(order[k]));
      check($sformatf("rr_addr%0d", k), 64'(mst_req.ar.addr), 64'(32'h100 + 32'(order[k]) * 32'd16));
    end
    check("rr_port2_isolated", 64'(p2_bad), 64'd0);
    @(posedge clk); #1;

    // Async reset in the middle of a write burst on port 2.
    drive('0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    drive('{4'b0000,4'b0100,4'b0100,0,1,1,0,0,0,0});
    wait_mst(1'b1, seen, p2t);
    check("wr_beat1_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
    check("wr_beat2_fwd", 64'(mst_req.w_valid), 64'd1);
    check("wr_beat2_gnt", 64'(gnt_idx), 64'd2);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_gnt", 64'(gnt_idx), 64'd0);
    check("rst_mst_req_zero", 64'(mst_req == '0), 64'd1);
    check("rst_slv_resp_zero", 64'(slv_resp == '0), 64'd1);
    drive('0);
    @(posedge clk); #1 rst = 1'b0;

    // Five read grants to port 0, then the counters.
    drive('{4'b0001,4'b0000,4'b0000,1,0,0,0,1,1,0});
    for (int k = 0; k < 5; k++) begin
      wait_mst(1'b0, seen, p2t);
      check($sformatf("cnt_grant%0d", k), 64'(seen && gnt_idx == 2'd0), 64'd1);
    end
    @(posedge clk); #1;
    drive('{4'b0000,4'b0000,4'b0000,1,0,0,0,1,1,0});
    repeat (3) @(posedge clk);
    #1 drive('0);
    @(negedge clk);
    check("cnt_busy_done", 64'(busy), 64'd0);
    check("cnt_port0", 64'(gnt_cnt[0]), 64'(EXP_CNT0));
    check("cnt_port1", 64'(gnt_cnt[1]), 64'd0);
    check("cnt_port2", 64'(gnt_cnt[2]), 64'd0);
    check("cnt_port3", 64'(gnt_cnt[3]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
